// File: rtl/fib_wb_regs.sv
// Wishbone slave register file for the multi-channel Fibonacci project.
// It holds the channel enables and clock selects, reads back channel values, and keeps sticky wrap interrupts.
module fib_wb_regs #(
    parameter logic [31:0] BASE_ADDRESS = 32'h3000_0000,
    parameter int          NUM_CHANNELS = 4,
    parameter int          CLOCK_WIDTH  = 6,
    parameter int          VAL_WIDTH    = 30
) (
    input  logic                                wb_clk_i,
    input  logic                                wb_rst_ni,
    input  logic                                wbs_stb_i,
    input  logic                                wbs_cyc_i,
    input  logic                                wbs_we_i,
    input  logic [3:0]                          wbs_sel_i,
    input  logic [31:0]                         wbs_adr_i,
    input  logic [31:0]                         wbs_dat_i,
    output logic                                wbs_ack_o,
    output logic [31:0]                         wbs_dat_o,
    input  logic [NUM_CHANNELS*VAL_WIDTH-1:0]   ch_val_i,
    input  logic [NUM_CHANNELS-1:0]             ch_wrap_i,
    output logic [NUM_CHANNELS-1:0]             ch_enable_o,
    output logic [NUM_CHANNELS*CLOCK_WIDTH-1:0] ch_clock_o,
    output logic [NUM_CHANNELS-1:0]             irq_o,
    output logic                                panic_o
);

    localparam logic [31:0]            WIN_BYTES     = 32'h20 + 32'(8 * NUM_CHANNELS);
    localparam logic [31:0]            ID_VALUE      = 32'h4669_6232;
    localparam logic [31:0]            CFG_VALUE     = {16'h0, 8'(NUM_CHANNELS), 8'h02};
    localparam logic [31:0]            SCRATCH_RESET = 32'hF00D_F00D;
    localparam logic [CLOCK_WIDTH-1:0] CLOCK_RESET   = CLOCK_WIDTH'(1);

    logic                    ack_q;
    logic [31:0]             dat_q;
    logic [NUM_CHANNELS-1:0] mask_q;
    logic [NUM_CHANNELS-1:0] status_q;
    logic [NUM_CHANNELS-1:0] enable_q;
    logic [31:0]             scratch_q;
    logic                    panic_q;

    logic [31:0] offset;
    logic        in_window;
    logic        req;
    logic        wr;
    logic [5:0]  word_idx;
    logic        is_chan;
    logic        is_val;
    logic [2:0]  chan_idx;
    logic [31:0] sel_mask;
    logic [31:0] rd_data;
    logic [31:0] clk_word [8];
    logic [31:0] val_word [8];

    logic                    wr_mask;
    logic                    wr_status;
    logic                    wr_enable;
    logic                    wr_scratch;
    logic                    wr_panic;
    logic                    wr_clk;
    logic [NUM_CHANNELS-1:0] status_clr;

    // Handshake: a request is valid when stb & cyc & in-window & !ack. That cycle is the only
    // accept cycle. ack follows for exactly one cycle, so a held strobe is acked every other cycle.
    assign offset    = wbs_adr_i - BASE_ADDRESS;
    assign in_window = (wbs_adr_i >= BASE_ADDRESS) && (offset < WIN_BYTES);
    assign req       = wbs_stb_i & wbs_cyc_i & in_window & ~ack_q;
    assign wr        = req & wbs_we_i;

    assign word_idx = offset[7:2];
    assign is_chan  = (word_idx >= 6'd8);
    assign is_val   = word_idx[0];
    assign chan_idx = 3'((word_idx - 6'd8) >> 1);
    assign sel_mask = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}}, {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};

    always_comb begin
        wr_mask    = 1'b0;
        wr_status  = 1'b0;
        wr_enable  = 1'b0;
        wr_scratch = 1'b0;
        wr_panic   = 1'b0;
        wr_clk     = 1'b0;
        if (wr) begin
            if (is_chan) begin
                wr_clk = ~is_val;
            end else begin
                case (word_idx)
                    6'd2:    wr_mask    = 1'b1;
                    6'd3:    wr_status  = 1'b1;
                    6'd4:    wr_enable  = 1'b1;
                    6'd5:    wr_scratch = 1'b1;
                    6'd6:    wr_panic   = |wbs_sel_i;
                    default: ;
                endcase
            end
        end
    end

    // All per-channel bit fields fit in byte lane 0 because there are at most 8 channels.
    assign status_clr = (wr_status && wbs_sel_i[0]) ? wbs_dat_i[NUM_CHANNELS-1:0] : '0;

    always_comb begin
        rd_data = '0;
        if (is_chan) begin
            rd_data = is_val ? val_word[chan_idx] : clk_word[chan_idx];
        end else begin
            case (word_idx)
                6'd0:    rd_data = ID_VALUE;
                6'd1:    rd_data = CFG_VALUE;
                6'd2:    rd_data = 32'(mask_q);
                6'd3:    rd_data = 32'(status_q);
                6'd4:    rd_data = 32'(enable_q);
                6'd5:    rd_data = scratch_q;
                6'd6:    rd_data = {31'b0, panic_q};
                default: rd_data = '0;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            ack_q     <= 1'b0;
            dat_q     <= '0;
            mask_q    <= '0;
            status_q  <= '0;
            enable_q  <= '1;
            scratch_q <= SCRATCH_RESET;
            panic_q   <= 1'b0;
        end else begin
            ack_q    <= req;
            dat_q    <= (req && !wbs_we_i) ? rd_data : '0;
            // A wrap pulse in the same cycle as a clear wins, so no event is lost.
            status_q <= (status_q & ~status_clr) | ch_wrap_i;
            if (wr_mask && wbs_sel_i[0])
                mask_q <= wbs_dat_i[NUM_CHANNELS-1:0];
            if (wr_enable && wbs_sel_i[0])
                enable_q <= wbs_dat_i[NUM_CHANNELS-1:0];
            if (wr_scratch)
                scratch_q <= (scratch_q & ~sel_mask) | (wbs_dat_i & sel_mask);
            if (wr_panic)
                panic_q <= 1'b1;
        end
    end

    for (genvar c = 0; c < 8; c++) begin : g_chan
        if (c < NUM_CHANNELS) begin : g_live
            logic [CLOCK_WIDTH-1:0] clk_q;

            always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
                if (!wb_rst_ni)
                    clk_q <= CLOCK_RESET;
                else if (wr_clk && chan_idx == 3'(c))
                    clk_q <= (clk_q & ~sel_mask[CLOCK_WIDTH-1:0])
                           | (wbs_dat_i[CLOCK_WIDTH-1:0] & sel_mask[CLOCK_WIDTH-1:0]);
            end

            assign ch_clock_o[c*CLOCK_WIDTH +: CLOCK_WIDTH] = clk_q;
            assign clk_word[c] = 32'(clk_q);
            assign val_word[c] = 32'(ch_val_i[c*VAL_WIDTH +: VAL_WIDTH]);
        end else begin : g_none
            assign clk_word[c] = '0;
            assign val_word[c] = '0;
        end
    end

    assign wbs_ack_o   = ack_q;
    assign wbs_dat_o   = dat_q;
    assign ch_enable_o = enable_q;
    assign irq_o       = status_q & mask_q;
    assign panic_o     = panic_q;

endmodule
